onehot_hit_counter: RTL and testbench

ONEHOT_HIT_COUNTER -- requirements
Module: onehot_hit_counter

---
 rtl/onehot_hit_counter.sv | 145 ++++++++++++++
 tb/tb_onehot_hit_counter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_hit_counter.sv
// Purpose  : per-line hit counters fed by a 3-to-8 decoder word, with malformed-word error tracking and an 8-entry dump sweep.
// Latency  : counters update at the accepting edge; each dump entry appears one edge after it is loaded (pre-update values).
// Backpres.: none; words are accepted whenever valid=1, and dump_start is ignored while a sweep is running (busy=1).
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   valid, in_onehot  decoder word and its qualifier
//   clr               synchronous clear of counters and error state (wins over valid)
//   dump_start        request a sweep of cnt[0..7] onto out_idx/out_data
//   busy              sweep in progress
//   out_valid         out_idx/out_data qualifier; both hold their last value when low
//   err_flag, err_cnt sticky malformed-word flag and saturating malformed-word count
module onehot_hit_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic [7:0]       in_onehot,
   input  logic             clr,
   input  logic             dump_start,
   output logic             busy,
   output logic             out_valid,
   output logic [2:0]       out_idx,
   output logic [CNT_W-1:0] out_data,
   output logic             err_flag,
   output logic [7:0]       err_cnt
);

   typedef enum logic {
      IDLE = 1'b0,
      DUMP = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt [8];

   // Bit 3 of dump_idx marks "all eight entries loaded": the sweep ends one
   // edge after index 7 is presented.
   logic [3:0]       dump_idx;
   logic [3:0]       dump_idx_nxt;
   logic             out_valid_nxt;
   logic [2:0]       out_idx_nxt;
   logic [CNT_W-1:0] out_data_nxt;

   logic [3:0]       pop;
   logic             well_formed;
   logic [2:0]       hit_line;

   // Popcount and bit position of the incoming word. hit_line is only
   // meaningful when exactly one bit is set.
   always_comb begin
      pop      = '0;
      hit_line = '0;
      for (int k = 0; k < 8; k++) begin
         pop = pop + {3'b000, in_onehot[k]};
         if (in_onehot[k]) begin
            hit_line = 3'(k);
         end
      end
      well_formed = (pop == 4'd1);
   end

   // Counters and error state. clr shares the reset path so a word arriving
   // alongside clr is discarded.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int k = 0; k < 8; k++) begin
            cnt[k] <= '0;
         end
         err_flag <= 1'b0;
         err_cnt  <= 8'd0;
      end else if (valid) begin
         if (well_formed) begin
            if (cnt[hit_line] != CNT_MAX) begin
               cnt[hit_line] <= cnt[hit_line] + CNT_ONE;
            end
         end else begin
            err_flag <= 1'b1;
            if (err_cnt != 8'hFF) begin
               err_cnt <= err_cnt + 8'd1;
            end
         end
      end
   end

   // Sweep control. Output registers sample cnt[] before this edge's update,
   // so a concurrent hit or clr is not visible in the entry loaded at that edge.
   always_comb begin
      state_nxt     = state;
      dump_idx_nxt  = dump_idx;
      out_valid_nxt = 1'b0;
      out_idx_nxt   = out_idx;
      out_data_nxt  = out_data;
      case (state)
         IDLE: begin
            if (dump_start) begin
               state_nxt     = DUMP;
               out_valid_nxt = 1'b1;
               out_idx_nxt   = 3'd0;
               out_data_nxt  = cnt[0];
               dump_idx_nxt  = 4'd1;
            end
         end
         DUMP: begin
            if (dump_idx[3]) begin
               state_nxt    = IDLE;
               dump_idx_nxt = 4'd0;
            end else begin
               out_valid_nxt = 1'b1;
               out_idx_nxt   = dump_idx[2:0];
               out_data_nxt  = cnt[dump_idx[2:0]];
               dump_idx_nxt  = dump_idx + 4'd1;
            end
         end
         default: begin
            state_nxt    = IDLE;
            dump_idx_nxt = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         dump_idx  <= 4'd0;
         out_valid <= 1'b0;
         out_idx   <= 3'd0;
         out_data  <= '0;
      end else begin
         state     <= state_nxt;
         dump_idx  <= dump_idx_nxt;
         out_valid <= out_valid_nxt;
         out_idx   <= out_idx_nxt;
         out_data  <= out_data_nxt;
      end
   end

   assign busy = (state == DUMP);

endmodule

// File: tb/tb_onehot_hit_counter.sv
// Purpose  : directed bench for onehot_hit_counter with a reference model and output scoreboard.
// Latency  : expected dump entries are queued when the stimulus edge is modelled, popped when out_valid is seen.
// Backpres.: none; the bench drives one step per clock.
module tb_onehot_hit_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic [7:0] in_onehot;
   logic       clr;
   logic       dump_start;
   logic       busy;
   logic       out_valid;
   logic [2:0] out_idx;
   logic [7:0] out_data;
   logic       err_flag;
   logic [7:0] err_cnt;

   always #5 clk = ~clk;

   onehot_hit_counter #(.CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .valid      (valid),
      .in_onehot  (in_onehot),
      .clr        (clr),
      .dump_start (dump_start),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_idx    (out_idx),
      .out_data   (out_data),
      .err_flag   (err_flag),
      .err_cnt    (err_cnt)
   );

   typedef struct packed {
      logic [2:0] idx;
      logic [7:0] data;
   } rec_t;

   int   tests = 0;
   int   fails = 0;
   rec_t sb[$];

   // Reference model state.
   int         m_cnt [8];
   int         m_err;
   logic       m_eflag;
   logic       m_dump;
   int         m_idx;
   logic [2:0] m_last_idx;
   logic [7:0] m_last_data;

   // Values captured from the DUT during the current sweep.
   int seen [8];
   int nvalid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 8; k++) m_cnt[k] = 0;
      m_err       = 0;
      m_eflag     = 1'b0;
      m_dump      = 1'b0;
      m_idx       = 0;
      m_last_idx  = 3'd0;
      m_last_data = 8'd0;
      sb.delete();
   endtask

   // Drive one cycle of stimulus, advance the model for that edge, then check
   // every output one time unit after the edge.
   task automatic step(input logic v, input logic [7:0] w, input logic c,
                       input logic d, input logic r);
      logic exp_ov;
      rec_t want;
      int   pc;
      int   line;
      valid      = v;
      in_onehot  = w;
      clr        = c;
      dump_start = d;
      rst        = r;
      exp_ov     = 1'b0;
      if (r) begin
         model_reset();
      end else begin
         if (m_dump) begin
            if (m_idx == 8) begin
               m_dump = 1'b0;
            end else begin
               want.idx    = 3'(m_idx);
               want.data   = 8'(m_cnt[m_idx]);
               sb.push_back(want);
               m_last_idx  = want.idx;
               m_last_data = want.data;
               exp_ov      = 1'b1;
               m_idx++;
            end
         end else if (d) begin
            want.idx    = 3'd0;
            want.data   = 8'(m_cnt[0]);
            sb.push_back(want);
            m_last_idx  = want.idx;
            m_last_data = want.data;
            exp_ov      = 1'b1;
            m_dump      = 1'b1;
            m_idx       = 1;
         end
         if (c) begin
            for (int k = 0; k < 8; k++) m_cnt[k] = 0;
            m_err   = 0;
            m_eflag = 1'b0;
         end else if (v) begin
            pc   = 0;
            line = 0;
            for (int k = 0; k < 8; k++) begin
               if (w[k]) begin
                  pc++;
                  line = k;
               end
            end
            if (pc == 1) begin
               if (m_cnt[line] < 255) m_cnt[line]++;
            end else begin
               m_eflag = 1'b1;
               if (m_err < 255) m_err++;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      chk("busy", {31'd0, busy}, {31'd0, m_dump});
      if (out_valid === 1'b1) begin
         chk("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
         if (sb.size() != 0) begin
            want = sb.pop_front();
            chk("out_idx", {29'd0, out_idx}, {29'd0, want.idx});
            chk("out_data", {24'd0, out_data}, {24'd0, want.data});
            seen[out_idx] = int'(out_data);
            nvalid++;
         end
      end else begin
         chk("hold_idx", {29'd0, out_idx}, {29'd0, m_last_idx});
         chk("hold_data", {24'd0, out_data}, {24'd0, m_last_data});
      end
      chk("err_flag", {31'd0, err_flag}, {31'd0, m_eflag});
      chk("err_cnt", {24'd0, err_cnt}, 32'(m_err));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic start_collect();
      for (int k = 0; k < 8; k++) seen[k] = -1;
      nvalid = 0;
   endtask

   // Full sweep: start edge, seven more loads, one edge back to IDLE.
   task automatic sweep(input string tag);
      start_collect();
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      idle(8);
      chk({tag, "_nvalid"}, 32'(nvalid), 32'd8);
      chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic check_seen(input string tag, input int exp_a [8]);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("%s_cnt%0d", tag, k), 32'(seen[k]), 32'(exp_a[k]));
      end
   endtask

   initial begin
      rst        = 1'b1;
      valid      = 1'b0;
      in_onehot  = 8'h00;
      clr        = 1'b0;
      dump_start = 1'b0;
      model_reset();
      start_collect();

      // Reset, including reset beating clr/dump_start/valid in the same cycle.
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      idle(1);

      // Basic counting and sweep order.
      step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
      sweep("basic");
      check_seen("basic", '{1, 0, 2, 0, 0, 0, 0, 1});
      chk("basic_err_flag", {31'd0, err_flag}, 32'd0);

      // Malformed words; an unqualified word is ignored.
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h05, 1'b0, 1'b0, 1'b0);
      chk("malformed_err_cnt", {24'd0, err_cnt}, 32'd2);
      chk("malformed_err_flag", {31'd0, err_flag}, 32'd1);
      sweep("malformed");
      check_seen("malformed", '{0, 0, 0, 0, 0, 0, 0, 0});

      // Saturation of a counter and of the error count.
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
      sweep("sat");
      chk("sat_cnt4", 32'(seen[4]), 32'd255);
      chk("sat_cnt3", 32'(seen[3]), 32'd0);
      for (int i = 0; i < 256; i++) step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
      chk("sat_err_cnt", {24'd0, err_cnt}, 32'd255);

      // clr beats a same-cycle word; dump_start mid-sweep is not queued.
      step(1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
      chk("clrpri_err_flag", {31'd0, err_flag}, 32'd0);
      chk("clrpri_err_cnt", {24'd0, err_cnt}, 32'd0);
      start_collect();
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      idle(2);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      idle(6);
      chk("restart_nvalid", 32'(nvalid), 32'd8);
      chk("restart_cnt1", 32'(seen[1]), 32'd0);
      chk("restart_busy", {31'd0, busy}, 32'd0);

      // Hit on the line being loaded reports the pre-increment value.
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
      start_collect();
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      idle(2);
      step(1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
      idle(5);
      chk("coinc_cnt3", 32'(seen[3]), 32'd5);
      sweep("coinc2");
      chk("coinc2_cnt3", 32'(seen[3]), 32'd6);

      // clr during a sweep: later entries show cleared-then-updated counts.
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) step(1'b1, 8'(1 << k), 1'b0, 1'b0, 1'b0);
      start_collect();
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      idle(1);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(1);
      step(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
      idle(4);
      check_seen("midclr", '{1, 1, 1, 0, 0, 0, 1, 0});

      // Reset during the fourth out_valid cycle aborts the sweep.
      step(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
      start_collect();
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      idle(3);
      chk("abort_nvalid_before", 32'(nvalid), 32'd4);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_out_idx", {29'd0, out_idx}, 32'd0);
      idle(1);
      sweep("abort");
      check_seen("abort", '{0, 0, 0, 0, 0, 0, 0, 0});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
